seq_search: RTL and testbench
=============================

// Module: seq_search
// PURPOSE
//  Sequential key-search engine: DEPTH-entry table with per-entry valid bits, scanned one entry/clock.
//  Replaces the single-pair equality compare with a start/busy/done search returning hit + first match address.
//  Table written through a dedicated write port; sits between the table-load logic and the lookup client.
// PARAMETERS
//  A      8   address width; DEPTH = 2**A entries
//  D      8   data/key width
// PORTS
//  clk        in   1    clock, all logic rising-edge
//  rst        in   1    synchronous active-high reset
//  enble      in   1    search enable; low aborts a running scan
//  wr_en      in   1    table write strobe
//  wr_addr    in   A    write address
//  wr_data    in   D    write data
//  wr_vld     in   1    valid bit stored with wr_data (0 = invalidate entry)
//  start      in   1    search request pulse
//  key        in   D    search key, sampled when start accepted
//  key_mask   in   D    per-bit compare mask, 1 = compare (only with SEARCH_MASK_EN)
//  busy       out  1    high while scanning
//  done       out  1    one-cycle pulse, search result valid
//  hit        out  1    1 = match found
//  hit_addr   out  A    address of first (lowest) matching entry; 0 on miss
// BEHAVIOUR
//  Reset: FSM=IDLE, busy=0, done=0, hit=0, hit_addr=0, all valid bits=0; table data not reset.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: start & enble accepted -> latch key (and mask), ptr=0, go SCAN. start without enble ignored.
//   SCAN: compare entry[ptr]: match = valid[ptr] & (data[ptr]==key_l). busy=1.
//     match -> hit=1, hit_addr=ptr, go DONE.
//     no match & ptr==DEPTH-1 -> hit=0, hit_addr=0, go DONE (no wrap, ptr never exceeds DEPTH-1).
//     else ptr=ptr+1.
//     enble low in any SCAN cycle -> abort: go IDLE, hit=0, hit_addr=0, done not pulsed.
//   DONE: done=1 one cycle, busy=0, then IDLE.
//  Timing: start high in cycle t; entry k compared in t+1+k; done=1 in t+2+k (hit), t+1+DEPTH (miss).
//  hit/hit_addr registered, held stable from done until the next accepted start (cleared at accept).
//  start while SCAN or DONE: ignored, no queueing.
//  Writes allowed in any state, one per cycle; write completes at clock edge.
//  Write to the entry compared in the same cycle: compare uses pre-write contents.
//  Write to an already-scanned entry does not affect the running search.
//  Reset mid-scan: immediate IDLE, no done, valid bits cleared.
//  Compare is full D-bit equality; no partial/priority-encoder logic beyond first-hit ordering.
// CONFIGURATION
//  SEARCH_MASK_EN defined: key_mask port present, latched with key;
//    match = valid & (((data ^ key_l) & mask_l) == 0). mask all-0 matches first valid entry.
//  SEARCH_MASK_EN undefined: no key_mask port; exact D-bit equality.
// TESTING
//  1 Reset, write 0x11@0,0x22@1,0x33@2 (vld=1); start key=0x33 at t -> done t+4, hit=1, hit_addr=2.
//  2 Same table, key=0x44 -> done at t+1+DEPTH (t+257, A=8), hit=0, hit_addr=0, busy high 256 cycles.
//  3 Duplicate 0x55 @5 and @9; key=0x55 -> hit_addr=5; invalidate @5 (wr_vld=0), repeat -> hit_addr=9.
//  4 Key=0x33 @2, drop enble in cycle t+2 -> busy=0 next cycle, no done, hit=0; later start works.
//  5 Scan key=0x77, write 0x77@3 in cycle t+4 (entry 3 compared) -> miss; write @10 in t+4 -> hit_addr=10.
//  6 rst in mid-scan -> IDLE, no done; prior entries now miss (valid cleared). With SEARCH_MASK_EN:
//    entry 0xA5@4, key=0xAF mask=0xF0 -> hit_addr=4; mask=0xFF -> miss.

Source files
------------

// File: rtl/seq_search_if.sv
// Bus bundle for seq_search: table write port, search request and result.
// key_mask exists only when SEARCH_MASK_EN is defined.
interface seq_search_if #(
  parameter int A = 8,
  parameter int D = 8
);
  logic         enble;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         wr_vld;
  logic         start;
  logic [D-1:0] key;
`ifdef SEARCH_MASK_EN
  logic [D-1:0] key_mask;
`endif
  logic         busy;
  logic         done;
  logic         hit;
  logic [A-1:0] hit_addr;

  modport master (
`ifdef SEARCH_MASK_EN
    output key_mask,
`endif
    output enble, wr_en, wr_addr, wr_data, wr_vld, start, key,
    input  busy, done, hit, hit_addr
  );

  modport slave (
`ifdef SEARCH_MASK_EN
    input  key_mask,
`endif
    input  enble, wr_en, wr_addr, wr_data, wr_vld, start, key,
    output busy, done, hit, hit_addr
  );
endinterface

// File: rtl/seq_search.sv
// Sequential key-search engine: 2**A-entry table, one entry compared per clock,
// returns hit + lowest matching address. SEARCH_MASK_EN enables a per-bit key mask.
module seq_search #(
  parameter int A = 8,
  parameter int D = 8
) (
  input logic      clk,
  input logic      rst,
  seq_search_if.slave bus
);

  localparam int DEPTH = 2 ** A;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [D-1:0]     mem_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [1:0]       state_r;
  logic [A-1:0]     ptr_r;
  logic [D-1:0]     key_r;
  logic [D-1:0]     mask_r;
  logic             busy_r;
  logic             done_r;
  logic             hit_r;
  logic [A-1:0]     hit_addr_r;
  logic             match_s;
  logic             last_s;

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.hit      = hit_r;
  assign bus.hit_addr = hit_addr_r;

  // Table data storage; not reset, only the valid bits are.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Per-entry valid bits, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {DEPTH{1'b0}};
    end else if (bus.wr_en) begin
      valid_r[bus.wr_addr] <= bus.wr_vld;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Compare of the current entry; reads pre-write contents, so a same-cycle write is not seen.
  always_comb begin
    match_s = valid_r[ptr_r] & (((mem_r[ptr_r] ^ key_r) & mask_r) == {D{1'b0}});
    last_s  = (ptr_r == {A{1'b1}});
  end

  // Search FSM and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {A{1'b0}};
      key_r      <= {D{1'b0}};
      mask_r     <= {D{1'b1}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hit_r      <= 1'b0;
      hit_addr_r <= {A{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start && bus.enble) begin
            key_r      <= bus.key;
`ifdef SEARCH_MASK_EN
            mask_r     <= bus.key_mask;
`else
            mask_r     <= {D{1'b1}};
`endif
            ptr_r      <= {A{1'b0}};
            hit_r      <= 1'b0;
            hit_addr_r <= {A{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= ST_SCAN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          // Abort has priority over a match found in the same cycle.
          if (!bus.enble) begin
            hit_r      <= 1'b0;
            hit_addr_r <= {A{1'b0}};
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (match_s) begin
            hit_r      <= 1'b1;
            hit_addr_r <= ptr_r;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
          end else if (last_s) begin
            hit_r      <= 1'b0;
            hit_addr_r <= {A{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            ptr_r <= ptr_r + {{(A-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_search.sv
// Self-checking bench for seq_search: directed scenarios plus randomized searches
// checked against a table model (honours SEARCH_MASK_EN).
module tb_seq_search;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [7:0] ref_data [DEPTH];
  bit         ref_vld  [DEPTH];

  seq_search_if #(.A(8), .D(8)) bus ();
  seq_search #(.A(8), .D(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Lowest valid entry whose masked bits equal the key, or -1.
  function automatic int ref_search(input logic [7:0] k, input logic [7:0] m);
    for (int i = 0; i < DEPTH; i++) begin
      if (ref_vld[i] && (((ref_data[i] ^ k) & m) == 8'h00)) return i;
    end
    return -1;
  endfunction

  task automatic set_mask(input logic [7:0] m);
`ifdef SEARCH_MASK_EN
    bus.key_mask = m;
`endif
  endtask

  task automatic write_entry(input logic [7:0] a, input logic [7:0] d, input logic v);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_vld = v;
    ref_data[a] = d; ref_vld[a] = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Starts a search in cycle t; lat is the cycle offset at which done is seen.
  // Optionally injects a write (wr_cyc) or a second start (st_cyc) at a given offset.
  task automatic run_search(input logic [7:0] k, input logic [7:0] m,
                            input int wr_cyc, input logic [7:0] wa, input logic [7:0] wd,
                            input int st_cyc, input logic [7:0] st_key,
                            output logic h, output logic [7:0] ha, output int lat,
                            output int busy_cnt, output logic done_after, output logic hold_ok);
    bit seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.key = k; set_mask(m);
    lat = 0; busy_cnt = 0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1;
      bus.start = (lat == st_cyc);
      bus.key   = (lat == st_cyc) ? st_key : k;
      bus.wr_en = (lat == wr_cyc);
      if (lat == wr_cyc) begin
        bus.wr_addr = wa; bus.wr_data = wd; bus.wr_vld = 1'b1;
        ref_data[wa] = wd; ref_vld[wa] = 1'b1;
      end
    end
    bus.start = 1'b0; bus.wr_en = 1'b0;
    h = bus.hit; ha = bus.hit_addr;
    @(negedge clk);
    done_after = bus.done;
    hold_ok = (bus.hit === h) && (bus.hit_addr === ha);
  endtask

  task automatic test_reset;
    bus.enble = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = 8'h00; bus.wr_data = 8'h00;
    bus.wr_vld = 1'b0; bus.start = 1'b0; bus.key = 8'h00; set_mask(8'hFF);
    for (int i = 0; i < DEPTH; i++) begin ref_vld[i] = 1'b0; ref_data[i] = 8'h00; end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.hit !== 1'b0) $display("FAIL reset_hit got %b exp 0", bus.hit); else pass_cnt++;
    total_cnt++; if (bus.hit_addr !== 8'h00) $display("FAIL reset_hit_addr got %0d exp 0", bus.hit_addr); else pass_cnt++;
  endtask

  task automatic test_hit_and_miss;
    logic h, da, hold; logic [7:0] ha; int lat, bc;
    write_entry(8'd0, 8'h11, 1'b1);
    write_entry(8'd1, 8'h22, 1'b1);
    write_entry(8'd2, 8'h33, 1'b1);
    run_search(8'h33, 8'hFF, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (lat !== 4) $display("FAIL hit_latency got %0d exp 4", lat); else pass_cnt++;
    total_cnt++; if (h !== 1'b1 || ha !== 8'd2) $display("FAIL hit_result got %b/%0d exp 1/2", h, ha); else pass_cnt++;
    total_cnt++; if (da !== 1'b0 || !hold) $display("FAIL done_pulse got done=%b hold=%b exp 0/1", da, hold); else pass_cnt++;
    run_search(8'h44, 8'hFF, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (lat !== 257) $display("FAIL miss_latency got %0d exp 257", lat); else pass_cnt++;
    total_cnt++; if (h !== 1'b0 || ha !== 8'd0) $display("FAIL miss_result got %b/%0d exp 0/0", h, ha); else pass_cnt++;
    total_cnt++; if (bc !== 256) $display("FAIL miss_busy_cycles got %0d exp 256", bc); else pass_cnt++;
  endtask

  task automatic test_duplicates;
    logic h, da, hold; logic [7:0] ha; int lat, bc;
    write_entry(8'd5, 8'h55, 1'b1);
    write_entry(8'd9, 8'h55, 1'b1);
    run_search(8'h55, 8'hFF, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b1 || ha !== 8'd5) $display("FAIL dup_first got %b/%0d exp 1/5", h, ha); else pass_cnt++;
    total_cnt++; if (lat !== 7) $display("FAIL dup_first_latency got %0d exp 7", lat); else pass_cnt++;
    write_entry(8'd5, 8'h55, 1'b0);
    run_search(8'h55, 8'hFF, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b1 || ha !== 8'd9) $display("FAIL dup_invalidated got %b/%0d exp 1/9", h, ha); else pass_cnt++;
    total_cnt++; if (lat !== 11) $display("FAIL dup_inv_latency got %0d exp 11", lat); else pass_cnt++;
  endtask

  task automatic test_abort;
    logic h, da, hold; logic [7:0] ha; int lat, bc; int dcnt = 0;
    @(negedge clk); bus.start = 1'b1; bus.key = 8'h33; set_mask(8'hFF);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.enble = 1'b0;
    @(negedge clk);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.hit !== 1'b0) $display("FAIL abort_hit got %b exp 0", bus.hit); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) dcnt++;
      @(negedge clk);
    end
    total_cnt++; if (dcnt !== 0) $display("FAIL abort_no_done got %0d exp 0", dcnt); else pass_cnt++;
    bus.start = 1'b1; bus.key = 8'h22;
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL start_without_enble got busy %b exp 0", bus.busy); else pass_cnt++;
    bus.enble = 1'b1;
    run_search(8'h22, 8'hFF, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b1 || ha !== 8'd1 || lat !== 3) $display("FAIL after_abort got %b/%0d lat %0d exp 1/1 lat 3", h, ha, lat); else pass_cnt++;
  endtask

  task automatic test_write_during_scan;
    logic h, da, hold; logic [7:0] ha; int lat, bc;
    run_search(8'h77, 8'hFF, 4, 8'd3, 8'h77, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b0 || lat !== 257) $display("FAIL same_cycle_write got %b lat %0d exp 0 lat 257", h, lat); else pass_cnt++;
    write_entry(8'd3, 8'h77, 1'b0);
    run_search(8'h77, 8'hFF, 4, 8'd10, 8'h77, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b1 || ha !== 8'd10) $display("FAIL ahead_write got %b/%0d exp 1/10", h, ha); else pass_cnt++;
    total_cnt++; if (lat !== 12) $display("FAIL ahead_write_latency got %0d exp 12", lat); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic h, da, hold; logic [7:0] ha; int lat, bc;
    run_search(8'h55, 8'hFF, -1, 8'h00, 8'h00, 2, 8'h11, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b1 || ha !== 8'd9 || lat !== 11) $display("FAIL start_while_scan got %b/%0d lat %0d exp 1/9 lat 11", h, ha, lat); else pass_cnt++;
    run_search(8'h11, 8'hFF, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b1 || ha !== 8'd0 || lat !== 2) $display("FAIL back_to_back got %b/%0d lat %0d exp 1/0 lat 2", h, ha, lat); else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan;
    logic h, da, hold; logic [7:0] ha; int lat, bc; int dcnt = 0;
    @(negedge clk); bus.start = 1'b1; bus.key = 8'h44; set_mask(8'hFF);
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
    @(negedge clk); rst = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", bus.busy); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (bus.done) dcnt++;
      @(negedge clk);
    end
    total_cnt++; if (dcnt !== 0) $display("FAIL rst_mid_no_done got %0d exp 0", dcnt); else pass_cnt++;
    run_search(8'h11, 8'hFF, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b0 || lat !== 257) $display("FAIL rst_valid_cleared got %b lat %0d exp 0 lat 257", h, lat); else pass_cnt++;
`ifdef SEARCH_MASK_EN
    write_entry(8'd4, 8'hA5, 1'b1);
    run_search(8'hAF, 8'hF0, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b1 || ha !== 8'd4) $display("FAIL mask_hit got %b/%0d exp 1/4", h, ha); else pass_cnt++;
    run_search(8'hAF, 8'hFF, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
    total_cnt++; if (h !== 1'b0) $display("FAIL mask_full_miss got %b exp 0", h); else pass_cnt++;
`endif
  endtask

  task automatic test_random;
    logic h, da, hold; logic [7:0] ha, k, m; int lat, bc, exp_idx, exp_lat;
    for (int i = 0; i < 24; i++) begin
      write_entry(8'($urandom_range(0, 40)), 8'(8'hC0 + $urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    for (int n = 0; n < 8; n++) begin
      k = 8'(8'hC0 + $urandom_range(0, 8));
`ifdef SEARCH_MASK_EN
      m = 8'($urandom);
`else
      m = 8'hFF;
`endif
      exp_idx = ref_search(k, m);
      exp_lat = (exp_idx >= 0) ? exp_idx + 2 : 257;
      run_search(k, m, -1, 8'h00, 8'h00, -1, 8'h00, h, ha, lat, bc, da, hold);
      total_cnt++; if (h !== (exp_idx >= 0)) $display("FAIL rand_hit key %h got %b exp %b", k, h, exp_idx >= 0); else pass_cnt++;
      total_cnt++; if (ha !== ((exp_idx >= 0) ? 8'(exp_idx) : 8'h00)) $display("FAIL rand_addr key %h got %0d exp %0d", k, ha, exp_idx); else pass_cnt++;
      total_cnt++; if (lat !== exp_lat) $display("FAIL rand_latency key %h got %0d exp %0d", k, lat, exp_lat); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_hit_and_miss();
    test_duplicates();
    test_abort();
    test_write_during_scan();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
